// File: rtl/threefish_round_sequencer_if.sv
// Handshake bundle between the Threefish round sequencer and its datapath / host.
interface threefish_round_sequencer_if #(
    parameter int ROUND_W  = 8,
    parameter int SUBKEY_W = 5
);
    logic                key_wr;
    logic                tweak_wr;
    logic                block_wr;
    logic                abort;
    logic                ack;
    logic                load_wr;
    logic                round_wr;
    logic                subkey_inj;
    logic [SUBKEY_W-1:0] subkey_idx;
    logic [ROUND_W-1:0]  round;
    logic                block_out_reg_wr;
    logic                busy;
    logic                valid;

    modport master (
        output key_wr, tweak_wr, block_wr, abort, ack,
        input  load_wr, round_wr, subkey_inj, subkey_idx, round,
               block_out_reg_wr, busy, valid
    );

    modport slave (
        input  key_wr, tweak_wr, block_wr, abort, ack,
        output load_wr, round_wr, subkey_inj, subkey_idx, round,
               block_out_reg_wr, busy, valid
    );
endinterface

// File: rtl/threefish_round_sequencer.sv
// Round/subkey control sequencer for the Threefish block datapath.
// Optional macro THREEFISH_SEQ_BACK2BACK_EN: launch the next job directly from DONE on ack.
module threefish_round_sequencer #(
    parameter int ROUNDS           = 72,
    parameter int INJ_PERIOD       = 4,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int ROUND_W          = 8,
    parameter int SUBKEY_W         = 5
) (
    input  logic clk,
    input  logic rst,
    threefish_round_sequencer_if.slave bus
);
    localparam int CYC_PER_INJ = INJ_PERIOD / ROUNDS_PER_CYCLE;
    localparam int PH_W        = (CYC_PER_INJ > 1) ? $clog2(CYC_PER_INJ) : 1;
    localparam logic [ROUND_W-1:0]  LAST_ROUND = ROUND_W'(ROUNDS - ROUNDS_PER_CYCLE);
    localparam logic [ROUND_W-1:0]  ROUND_STEP = ROUND_W'(ROUNDS_PER_CYCLE);
    localparam logic [PH_W-1:0]     PH_LAST    = PH_W'(CYC_PER_INJ - 1);
    localparam logic [SUBKEY_W-1:0] FINAL_IDX  = SUBKEY_W'(ROUNDS / INJ_PERIOD);

    generate
        if (ROUNDS_PER_CYCLE < 1 || INJ_PERIOD < 1 || ROUNDS < 1) begin : g_bad_zero
            $error("threefish_round_sequencer: ROUNDS, INJ_PERIOD, ROUNDS_PER_CYCLE must be positive");
        end
        if (ROUNDS % INJ_PERIOD != 0) begin : g_bad_rounds
            $error("threefish_round_sequencer: ROUNDS must be a multiple of INJ_PERIOD");
        end
        if (INJ_PERIOD % ROUNDS_PER_CYCLE != 0) begin : g_bad_rpc
            $error("threefish_round_sequencer: ROUNDS_PER_CYCLE must divide INJ_PERIOD");
        end
        if (ROUND_W < $clog2(ROUNDS)) begin : g_bad_round_w
            $error("threefish_round_sequencer: ROUND_W too small");
        end
        if (SUBKEY_W < $clog2(ROUNDS / INJ_PERIOD + 1)) begin : g_bad_subkey_w
            $error("threefish_round_sequencer: SUBKEY_W too small");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ROUND_W-1:0]  round_reg, round_next;
    logic [PH_W-1:0]     phase_reg, phase_next;
    logic [SUBKEY_W-1:0] sk_reg, sk_next;
    logic [2:0]          flag_reg, flag_next;
    logic [2:0]          strobe, pending;
    logic                go;

    logic                load_wr, round_wr, subkey_inj, block_out_reg_wr, valid;
    logic [SUBKEY_W-1:0] subkey_idx;
    logic [ROUND_W-1:0]  round;

    assign strobe = {bus.block_wr, bus.tweak_wr, bus.key_wr};

    // A write this cycle counts as already collected, so go can fire on the last strobe.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pending
            assign pending[gi] = flag_reg[gi] | strobe[gi];
        end
    endgenerate

    assign go = (&pending) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            round_reg <= '0;
            phase_reg <= '0;
            sk_reg    <= '0;
            flag_reg  <= '0;
        end else begin
            state_reg <= state_next;
            round_reg <= round_next;
            phase_reg <= phase_next;
            sk_reg    <= sk_next;
            flag_reg  <= flag_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        round_next       = round_reg;
        phase_next       = phase_reg;
        sk_next          = sk_reg;
        flag_next        = pending;
        load_wr          = 1'b0;
        round_wr         = 1'b0;
        subkey_inj       = 1'b0;
        subkey_idx       = '0;
        round            = '0;
        block_out_reg_wr = 1'b0;
        valid            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.abort) begin
                    flag_next = '0;
                end else if (go) begin
                    load_wr    = 1'b1;
                    flag_next  = '0;
                    round_next = '0;
                    phase_next = '0;
                    sk_next    = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                round_wr   = 1'b1;
                round      = round_reg;
                subkey_inj = (phase_reg == '0);
                subkey_idx = sk_reg;
                if (bus.abort) begin
                    state_next = IDLE;
                    flag_next  = '0;
                    round_next = '0;
                    phase_next = '0;
                    sk_next    = '0;
                end else if (round_reg == LAST_ROUND) begin
                    state_next = FINAL;
                    round_next = '0;
                    phase_next = '0;
                    sk_next    = '0;
                end else begin
                    round_next = round_reg + ROUND_STEP;
                    // phase tracks position inside an injection period; the subkey index follows its wrap
                    if (phase_reg == PH_LAST) begin
                        phase_next = '0;
                        sk_next    = sk_reg + SUBKEY_W'(1);
                    end else begin
                        phase_next = phase_reg + PH_W'(1);
                    end
                end
            end
            FINAL: begin
                subkey_inj = 1'b1;
                subkey_idx = FINAL_IDX;
                if (bus.abort) begin
                    state_next = IDLE;
                    flag_next  = '0;
                end else begin
                    block_out_reg_wr = 1'b1;
                    state_next       = DONE;
                end
            end
            DONE: begin
                valid = 1'b1;
                if (bus.abort) begin
                    state_next = IDLE;
                    flag_next  = '0;
                end else if (bus.ack) begin
`ifdef THREEFISH_SEQ_BACK2BACK_EN
                    if (go) begin
                        load_wr    = 1'b1;
                        flag_next  = '0;
                        round_next = '0;
                        phase_next = '0;
                        sk_next    = '0;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
            end
            default: begin
                state_next = IDLE;
                flag_next  = '0;
            end
        endcase
    end

    assign bus.load_wr          = load_wr;
    assign bus.round_wr         = round_wr;
    assign bus.subkey_inj       = subkey_inj;
    assign bus.subkey_idx       = subkey_idx;
    assign bus.round            = round;
    assign bus.block_out_reg_wr = block_out_reg_wr;
    assign bus.valid            = valid;
    assign bus.busy             = (state_reg != IDLE);
endmodule

// File: tb/tb_threefish_round_sequencer.sv
// Bench for threefish_round_sequencer: two configurations driven in lockstep against a job-timeline model.
module tb_threefish_round_sequencer;
`ifdef THREEFISH_SEQ_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   clk_run = 1'b1;

    always #5 if (clk_run) clk = ~clk;

    threefish_round_sequencer_if #(.ROUND_W(8), .SUBKEY_W(5)) ifa ();
    threefish_round_sequencer_if #(.ROUND_W(8), .SUBKEY_W(5)) ifb ();

    threefish_round_sequencer dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    threefish_round_sequencer #(
        .ROUNDS(80), .INJ_PERIOD(4), .ROUNDS_PER_CYCLE(4), .ROUND_W(8), .SUBKEY_W(5)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct packed {
        logic       load;
        logic       rw;
        logic       inj;
        logic [4:0] idx;
        logic [7:0] rnd;
        logic       bor;
        logic       busy;
        logic       valid;
    } obs_t;

    // mode 0 = idle, 1 = job in flight (k = cycles since go), 2 = result held
    typedef struct {
        int mode;
        int k;
        bit fk;
        bit ft;
        bit fb;
    } mdl_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    mdl_t ma = '{mode: 0, k: 0, fk: 1'b0, ft: 1'b0, fb: 1'b0};
    mdl_t mb = '{mode: 0, k: 0, fk: 1'b0, ft: 1'b0, fb: 1'b0};
    mdl_t na, nb;
    obs_t ea, eb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t obs_a();
        return {ifa.load_wr, ifa.round_wr, ifa.subkey_inj, ifa.subkey_idx, ifa.round,
                ifa.block_out_reg_wr, ifa.busy, ifa.valid};
    endfunction

    function automatic obs_t obs_b();
        return {ifb.load_wr, ifb.round_wr, ifb.subkey_inj, ifb.subkey_idx, ifb.round,
                ifb.block_out_reg_wr, ifb.busy, ifb.valid};
    endfunction

    // Expected outputs follow from how many cycles have elapsed since go.
    function automatic void model_eval(input mdl_t m, input int rounds, input int inj_p, input int rpc,
                                       input bit kw, input bit tw, input bit bw, input bit ab, input bit ak,
                                       output obs_t e, output mdl_t nm);
        int n;
        int r;
        bit go;
        n  = rounds / rpc;
        e  = '0;
        nm = m;
        go = (m.fk | kw) & (m.ft | tw) & (m.fb | bw);
        nm.fk = m.fk | kw;
        nm.ft = m.ft | tw;
        nm.fb = m.fb | bw;
        case (m.mode)
            0: begin
                if (ab) begin
                    nm.fk = 0; nm.ft = 0; nm.fb = 0;
                end else if (go) begin
                    e.load = 1'b1;
                    nm.fk = 0; nm.ft = 0; nm.fb = 0;
                    nm.mode = 1; nm.k = 1;
                end
            end
            1: begin
                e.busy = 1'b1;
                if (m.k <= n) begin
                    r     = (m.k - 1) * rpc;
                    e.rw  = 1'b1;
                    e.rnd = 8'(r);
                    e.inj = ((r % inj_p) == 0);
                    e.idx = 5'(r / inj_p);
                end else begin
                    e.inj = 1'b1;
                    e.idx = 5'(rounds / inj_p);
                    e.bor = !ab;
                end
                if (ab) begin
                    nm.mode = 0; nm.k = 0;
                    nm.fk = 0; nm.ft = 0; nm.fb = 0;
                end else if (m.k == n + 1) begin
                    nm.mode = 2;
                end else begin
                    nm.k = m.k + 1;
                end
            end
            default: begin
                e.busy  = 1'b1;
                e.valid = 1'b1;
                if (ab) begin
                    nm.mode = 0;
                    nm.fk = 0; nm.ft = 0; nm.fb = 0;
                end else if (ak) begin
                    if (B2B && go) begin
                        e.load = 1'b1;
                        nm.fk = 0; nm.ft = 0; nm.fb = 0;
                        nm.mode = 1; nm.k = 1;
                    end else begin
                        nm.mode = 0;
                    end
                end
            end
        endcase
    endfunction

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            ma = '{mode: 0, k: 0, fk: 1'b0, ft: 1'b0, fb: 1'b0};
            mb = '{mode: 0, k: 0, fk: 1'b0, ft: 1'b0, fb: 1'b0};
        end else begin
            model_eval(ma, 72, 4, 1, ifa.key_wr, ifa.tweak_wr, ifa.block_wr, ifa.abort, ifa.ack, ea, na);
            model_eval(mb, 80, 4, 4, ifb.key_wr, ifb.tweak_wr, ifb.block_wr, ifb.abort, ifb.ack, eb, nb);
            check("cycle_a", 32'(obs_a()), 32'(ea));
            check("cycle_b", 32'(obs_b()), 32'(eb));
            ma = na;
            mb = nb;
        end
    end

    task automatic drive(input bit k, input bit t, input bit b, input bit ab, input bit ak);
        ifa.key_wr = k; ifa.tweak_wr = t; ifa.block_wr = b; ifa.abort = ab; ifa.ack = ak;
        ifb.key_wr = k; ifb.tweak_wr = t; ifb.block_wr = b; ifb.abort = ab; ifb.ack = ak;
    endtask

    task automatic step(input bit k, input bit t, input bit b, input bit ab, input bit ak);
        @(posedge clk);
        #1;
        drive(k, t, b, ab, ak);
    endtask

    // Called right after the go strobes were driven; cycle 0 is the go cycle.
    task automatic run_job(input string tag);
        int a_fin = -1, b_fin = -1, a_val = -1, b_val = -1;
        int a_rw = 0, b_rw = 0, a_inj = 0, b_inj = 0;
        int a_last = -1, b_last = -1, a_fidx = -1, b_fidx = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) check({tag, "_load"}, 32'({ifa.load_wr, ifb.load_wr}), 32'h3);
            if (ifa.round_wr) begin a_rw++; a_last = int'(ifa.round); end
            if (ifb.round_wr) begin b_rw++; b_last = int'(ifb.round); end
            if (ifa.subkey_inj) a_inj++;
            if (ifb.subkey_inj) b_inj++;
            if (ifa.block_out_reg_wr && a_fin < 0) begin a_fin = k; a_fidx = int'(ifa.subkey_idx); end
            if (ifb.block_out_reg_wr && b_fin < 0) begin b_fin = k; b_fidx = int'(ifb.subkey_idx); end
            if (ifb.valid && b_val < 0) b_val = k;
            if (ifa.valid && a_val < 0) a_val = k;
            if (a_val >= 0) break;
            step(0, 0, 0, 0, 0);
        end
        check({tag, "_a_final_cyc"}, 32'(a_fin), 32'd73);
        check({tag, "_a_valid_cyc"}, 32'(a_val), 32'd74);
        check({tag, "_a_round_wr"}, 32'(a_rw), 32'd72);
        check({tag, "_a_inj"}, 32'(a_inj), 32'd19);
        check({tag, "_a_last_round"}, 32'(a_last), 32'd71);
        check({tag, "_a_final_idx"}, 32'(a_fidx), 32'd18);
        check({tag, "_b_final_cyc"}, 32'(b_fin), 32'd21);
        check({tag, "_b_valid_cyc"}, 32'(b_val), 32'd22);
        check({tag, "_b_round_wr"}, 32'(b_rw), 32'd20);
        check({tag, "_b_inj"}, 32'(b_inj), 32'd21);
        check({tag, "_b_last_round"}, 32'(b_last), 32'd76);
        check({tag, "_b_final_idx"}, 32'(b_fidx), 32'd20);
    endtask

    task automatic ack_both();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        check("after_ack_busy", 32'({ifa.busy, ifb.busy}), 32'h0);
    endtask

    initial begin
        bit found;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 32'(obs_a()), 32'h0);
        check("reset_b", 32'(obs_b()), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // full job, all strobes together
        step(1, 1, 1, 0, 0);
        run_job("job1");
        ack_both();

        // staggered strobes: key, tweak three cycles later, block at seven
        for (int c = 0; c < 7; c++) begin
            step(c == 0, c == 3, 0, 0, 0);
            @(negedge clk);
            check("stagger_noload", 32'({ifa.load_wr, ifb.load_wr}), 32'h0);
        end
        step(0, 0, 1, 0, 0);
        run_job("stagger");
        ack_both();

        // abort at round 30 with a stray key strobe collected mid-run
        step(1, 1, 1, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(i == 2, 0, 0, 0, 0);
            @(negedge clk);
            if (ifa.round_wr && ifa.round == 8'd29) begin found = 1'b1; break; end
        end
        check("abort_reach29", 32'(found), 32'h1);
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        check("abort_round", 32'(ifa.round), 32'd30);
        check("abort_bor", 32'({ifa.block_out_reg_wr, ifb.block_out_reg_wr}), 32'h0);
        step(0, 1, 1, 0, 0);
        @(negedge clk);
        check("abort_busy", 32'({ifa.busy, ifb.busy}), 32'h0);
        check("abort_flags_cleared", 32'({ifa.load_wr, ifb.load_wr}), 32'h0);
        step(1, 0, 0, 0, 0);
        run_job("after_abort");
        ack_both();

        // asynchronous reset with the clock stopped mid-run
        step(1, 1, 1, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        @(negedge clk);
        clk_run = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_a", 32'(obs_a()), 32'h0);
        check("async_rst_b", 32'(obs_b()), 32'h0);
        #2 rst = 1'b0;
        #1 clk_run = 1'b1;
        step(1, 1, 1, 0, 0);
        run_job("post_reset");
        ack_both();

        // strobes for the next job while busy, then ack
        step(1, 1, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(0, 0, 0, 0, 0);
            @(negedge clk);
            if (ifa.valid) begin found = 1'b1; break; end
        end
        check("b2b_reach_done", 32'(found), 32'h1);
        step(0, 0, 0, 0, 1);
        #1;
        check("b2b_load_in_ack", 32'({ifa.load_wr, ifb.load_wr}), B2B ? 32'h3 : 32'h0);
        step(0, 0, 0, 0, 0);
        #1;
        check("b2b_load_after_ack", 32'({ifa.load_wr, ifb.load_wr}), B2B ? 32'h0 : 32'h3);
        check("b2b_busy_after_ack", 32'({ifa.busy, ifb.busy}), B2B ? 32'h3 : 32'h0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(0, 0, 0, 0, 0);
            @(negedge clk);
            if (ifa.valid) begin found = 1'b1; break; end
        end
        check("b2b_second_done", 32'(found), 32'h1);
        ack_both();

        // random traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 80) == 0, $urandom_range(0, 3) == 0);
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/threefish_round_sequencer.md
Name: threefish_round_sequencer

Overview:
- Parametrised control sequencer for the Threefish block datapath; successor to the fixed 72-round block control.
- Collects key/tweak/block write strobes and launches the load.
- Steps round counter by ROUNDS_PER_CYCLE; flags subkey injections every INJ_PERIOD rounds plus final injection.
- Writes output register, holds result valid until acknowledged; supports abort and pre-loading the next job while busy.

Parameters:
ROUNDS, 72, total rounds (72 for 256/512-bit, 80 for 1024-bit)
INJ_PERIOD, 4, rounds between subkey injections
ROUNDS_PER_CYCLE, 1, unrolled rounds per clock; must divide INJ_PERIOD
ROUND_W, 8, width of outRound; must be >= clog2(ROUNDS)
SUBKEY_W, 5, width of outSubkeyIdx; must be >= clog2(ROUNDS/INJ_PERIOD+1)

Ports:
inClk  in  1  clock, rising edge
inRst  in  1  asynchronous active-high reset
inKeyWr  in  1  key register written this cycle
inTweakWr  in  1  tweak register written this cycle
inBlockWr  in  1  plaintext block register written this cycle
inAbort  in  1  abandon current job
inOutAck  in  1  consumer has taken the result
outLoadWr  out  1  copy input regs into round register (combinational, go cycle)
outRoundWr  out  1  round register update enable
outSubkeyInj  out  1  add subkey before this cycle's rounds (or final add)
outSubkeyIdx  out  SUBKEY_W  subkey index s
outRound  out  ROUND_W  index of first round executed this cycle
outBlockOutRegWr  out  1  capture final state into output register
outBusy  out  1  job in progress or result pending
outValid  out  1  output register holds unacknowledged result

Behaviour:
- Reset (async, immediate): state IDLE, sticky flags 0, round counter 0; every output 0.
- Sticky flags fK/fT/fB set by corresponding write strobe in any state; cleared on go and on abort.
- States: IDLE, RUN, FINAL, DONE.
- IDLE: go = (fK|inKeyWr)&(fT|inTweakWr)&(fB|inBlockWr). On go: outLoadWr=1 same cycle, flags cleared, counter r=0, next RUN. outBusy=0.
- RUN: outRoundWr=1, outRound=r, outSubkeyInj=1 when r mod INJ_PERIOD==0, outSubkeyIdx=r/INJ_PERIOD; r += ROUNDS_PER_CYCLE; when r+ROUNDS_PER_CYCLE==ROUNDS, next FINAL.
- FINAL (one cycle): outSubkeyInj=1, outSubkeyIdx=ROUNDS/INJ_PERIOD, outBlockOutRegWr=1, outRoundWr=0; next DONE.
- DONE: outValid=1 until inOutAck sampled high; then IDLE next cycle.
- Outside RUN/FINAL: outRound=0, outSubkeyIdx=0.
- Latency, go at cycle T: RUN T+1..T+N (N=ROUNDS/ROUNDS_PER_CYCLE), FINAL T+N+1, outValid from T+N+2.
- outBusy=1 in RUN, FINAL, DONE.
- Strobes during RUN/FINAL/DONE only set flags; current job unaffected.
- inAbort in RUN/FINAL/DONE: next state IDLE, counter 0, flags cleared, no further outBlockOutRegWr. Abort wins over go, ack and FINAL transition. In IDLE: clears flags, suppresses go that cycle.
- inOutAck outside DONE ignored.
- Illegal parameters (ROUNDS mod INJ_PERIOD!=0, INJ_PERIOD mod ROUNDS_PER_CYCLE!=0, widths too small) stop elaboration with an error.

Optional Feature:
THREEFISH_SEQ_BACK2BACK_EN
- Defined: in DONE, if inOutAck=1, inAbort=0 and go condition (flags OR same-cycle strobes) true, then outLoadWr=1 that cycle, flags cleared, next state RUN directly (skips IDLE).
- Undefined: ack always returns to IDLE; earliest next load is the cycle after.

Test Plan:
- Defaults, all three strobes at cycle 0 -> outLoadWr@0; outRoundWr@1..72 with outRound 0..71; outSubkeyInj at rounds 0,4,..,68 idx 0..17; FINAL@73 idx 18 + outBlockOutRegWr; outValid from 74 until ack.
- Key@0, tweak@3, block@7 -> no load before 7; outLoadWr@7; FINAL@80.
- ROUNDS=80, ROUNDS_PER_CYCLE=4 -> 20 RUN cycles, outRound 0,4,..,76, outSubkeyInj every cycle idx 0..19; FINAL idx 20 at go+21.
- inAbort at outRound=30 -> IDLE next cycle; outBusy=0; no outBlockOutRegWr; flags 0.
- inRst asserted mid-RUN with clock stopped -> all outputs 0 immediately; after release a fresh 3-strobe go runs a full job.
- Three strobes during RUN, ack in DONE -> with macro outLoadWr in the ack cycle and RUN next; without macro IDLE then outLoadWr one cycle later.
